// File: rtl/glyph_blitter_pkg.sv
// Shared font geometry and pipeline bundle types for the glyph blitter.
// Font geometry is common to every font_rom user.
package glyph_blitter_pkg;

  localparam int GLYPH_W     = 32;
  localparam int GLYPH_ROWS  = 32;
  localparam int GLYPH_IDX_W = 3;
  localparam int FONT_AW     = 8;
  localparam int COL_W       = 5;

  typedef logic [GLYPH_IDX_W-1:0] glyph_t;

  typedef struct packed {
    logic             hit;
    logic [COL_W-1:0] col;
    logic             de;
    logic             hs;
    logic             vs;
  } st1_t;

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } sync_t;

  function automatic logic [FONT_AW-1:0] rom_addr(
    input glyph_t           g,
    input logic [COL_W-1:0] row
  );
    return {g, row};
  endfunction

endpackage

// File: rtl/glyph_blitter_if.sv
// Host command channel: valid/ready update of glyph index, position and enable.
interface glyph_blitter_if #(
  parameter int X_W = 11,
  parameter int Y_W = 10
);
  import glyph_blitter_pkg::*;

  logic           cmd_valid;
  logic           cmd_ready;
  glyph_t         cmd_glyph;
  logic [X_W-1:0] cmd_x;
  logic [Y_W-1:0] cmd_y;
  logic           cmd_en;

  modport master (
    output cmd_valid, cmd_glyph, cmd_x, cmd_y, cmd_en,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_glyph, cmd_x, cmd_y, cmd_en,
    output cmd_ready
  );

endinterface

// File: rtl/glyph_blitter_cmd_regs.sv
// Shadow/active glyph registers; shadow is copied to active on the vsync
// edge into its active level so the drawn glyph never changes mid-frame.
module glyph_blitter_cmd_regs
  import glyph_blitter_pkg::*;
#(
  parameter int X_W    = 11,
  parameter int Y_W    = 10,
  parameter bit VS_POL = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  glyph_blitter_if.slave cmd,
  input  logic           i_vs,
  output logic           o_en,
  output glyph_t         o_glyph,
  output logic [X_W-1:0] o_x,
  output logic [Y_W-1:0] o_y,
  output logic           o_commit
);

  logic           r_vs_d;
  logic           r_pending;
  logic           r_sh_en;
  glyph_t         r_sh_glyph;
  logic [X_W-1:0] r_sh_x;
  logic [Y_W-1:0] r_sh_y;
  logic           r_act_en;
  glyph_t         r_act_glyph;
  logic [X_W-1:0] r_act_x;
  logic [Y_W-1:0] r_act_y;

  logic w_edge;
  logic w_accept;
  logic w_commit;

  assign w_edge   = (i_vs == VS_POL) && (r_vs_d != VS_POL);
  assign w_commit = w_edge & r_pending;
  assign w_accept = cmd.cmd_valid & ~r_pending;

  assign cmd.cmd_ready = ~r_pending;
  assign o_commit      = w_commit;
  assign o_en          = r_act_en;
  assign o_glyph       = r_act_glyph;
  assign o_x           = r_act_x;
  assign o_y           = r_act_y;

  // Edge detector resets to the active level: no spurious commit at release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vs_d      <= VS_POL;
      r_pending   <= 1'b0;
      r_sh_en     <= 1'b0;
      r_sh_glyph  <= '0;
      r_sh_x      <= '0;
      r_sh_y      <= '0;
      r_act_en    <= 1'b0;
      r_act_glyph <= '0;
      r_act_x     <= '0;
      r_act_y     <= '0;
    end else begin
      r_vs_d <= i_vs;
      if (w_accept) begin
        r_sh_en    <= cmd.cmd_en;
        r_sh_glyph <= cmd.cmd_glyph;
        r_sh_x     <= cmd.cmd_x;
        r_sh_y     <= cmd.cmd_y;
        r_pending  <= 1'b1;
      end else if (w_commit) begin
        r_pending <= 1'b0;
      end
      if (w_commit) begin
        r_act_en    <= r_sh_en;
        r_act_glyph <= r_sh_glyph;
        r_act_x     <= r_sh_x;
        r_act_y     <= r_sh_y;
      end
    end
  end

endmodule

// File: rtl/glyph_blitter.sv
// Pixel-path glyph overlay: coords -> font_rom address, row word -> pix_on,
// with de/hs/vs delayed to match the two-stage ROM pipeline.
module glyph_blitter
  import glyph_blitter_pkg::*;
#(
  parameter int X_W        = 11,
  parameter int Y_W        = 10,
  parameter int SCALE_LOG2 = 0,
  parameter bit VS_POL     = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [X_W-1:0]     px_in,
  input  logic [Y_W-1:0]     py_in,
  input  logic               de_in,
  input  logic               hs_in,
  input  logic               vs_in,
  glyph_blitter_if.slave     cmd,
  output logic [FONT_AW-1:0] rom_ad,
  output logic               rom_ce,
  output logic               rom_oce,
  output logic               rom_reset,
  input  logic [31:0]        rom_dout,
  output logic               pix_on,
  output logic               de_out,
  output logic               hs_out,
  output logic               vs_out,
  output logic               commit
);

  localparam int BOX = GLYPH_W << SCALE_LOG2;
  localparam logic [X_W:0] BOX_X = (X_W+1)'(BOX);
  localparam logic [Y_W:0] BOX_Y = (Y_W+1)'(BOX);

  logic           w_act_en;
  glyph_t         w_act_glyph;
  logic [X_W-1:0] w_act_x;
  logic [Y_W-1:0] w_act_y;
  logic [X_W:0]   w_dx;
  logic [Y_W:0]   w_dy;
  logic           w_hit0;

  st1_t  r_s1;
  sync_t r_s2;
  logic  r_pix;

  glyph_blitter_cmd_regs #(
    .X_W    (X_W),
    .Y_W    (Y_W),
    .VS_POL (VS_POL)
  ) u_regs (
    .clk      (clk),
    .reset    (reset),
    .cmd      (cmd),
    .i_vs     (vs_in),
    .o_en     (w_act_en),
    .o_glyph  (w_act_glyph),
    .o_x      (w_act_x),
    .o_y      (w_act_y),
    .o_commit (commit)
  );

  // Extra borrow bit: left/above the box, or past the coordinate wrap, misses.
  assign w_dx = {1'b0, px_in} - {1'b0, w_act_x};
  assign w_dy = {1'b0, py_in} - {1'b0, w_act_y};

  assign w_hit0 = w_act_en & de_in & (w_dx < BOX_X) & (w_dy < BOX_Y);

  assign rom_ad    = rom_addr(w_act_glyph, w_dy[SCALE_LOG2 +: COL_W]);
  assign rom_ce    = 1'b1;
  assign rom_oce   = 1'b1;
  assign rom_reset = reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1 <= '0;
    end else begin
      r_s1.hit <= w_hit0;
      r_s1.col <= w_dx[SCALE_LOG2 +: COL_W];
      r_s1.de  <= de_in;
      r_s1.hs  <= hs_in;
      r_s1.vs  <= vs_in;
    end
  end

  // Bit 31 of the row word is the leftmost pixel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pix <= 1'b0;
      r_s2  <= '0;
    end else begin
      r_pix   <= r_s1.hit & rom_dout[5'(GLYPH_W-1) - r_s1.col];
      r_s2.de <= r_s1.de;
      r_s2.hs <= r_s1.hs;
      r_s2.vs <= r_s1.vs;
    end
  end

  assign pix_on = r_pix;
  assign de_out = r_s2.de;
  assign hs_out = r_s2.hs;
  assign vs_out = r_s2.vs;

endmodule

// File: tb/tb_glyph_blitter.sv
// Directed bench: unscaled and 2x blitters side by side, each on its own ROM.
module tb_glyph_blitter;
  import glyph_blitter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] px;
  logic [9:0]  py;
  logic        de, hs, vs;

  always #5 clk = ~clk;

  glyph_blitter_if #(.X_W(11), .Y_W(10)) c0 ();
  glyph_blitter_if #(.X_W(11), .Y_W(10)) c1 ();

  logic [7:0]  ad0, ad1;
  logic        ce0, oce0, rr0, ce1, oce1, rr1;
  logic [31:0] dout0, dout1;
  logic        pix0, deo0, hso0, vso0, cm0;
  logic        pix1, deo1, hso1, vso1, cm1;

  glyph_blitter #(.X_W(11), .Y_W(10), .SCALE_LOG2(0), .VS_POL(1'b1)) u0 (
    .clk(clk), .reset(reset), .px_in(px), .py_in(py), .de_in(de),
    .hs_in(hs), .vs_in(vs), .cmd(c0.slave), .rom_ad(ad0),
    .rom_ce(ce0), .rom_oce(oce0), .rom_reset(rr0), .rom_dout(dout0),
    .pix_on(pix0), .de_out(deo0), .hs_out(hso0), .vs_out(vso0),
    .commit(cm0)
  );

  glyph_blitter #(.X_W(11), .Y_W(10), .SCALE_LOG2(1), .VS_POL(1'b1)) u1 (
    .clk(clk), .reset(reset), .px_in(px), .py_in(py), .de_in(de),
    .hs_in(hs), .vs_in(vs), .cmd(c1.slave), .rom_ad(ad1),
    .rom_ce(ce1), .rom_oce(oce1), .rom_reset(rr1), .rom_dout(dout1),
    .pix_on(pix1), .de_out(deo1), .hs_out(hso1), .vs_out(vso1),
    .commit(cm1)
  );

  logic [31:0] mem [256];

  always @(posedge clk) begin
    dout0 <= mem[ad0];
    dout1 <= mem[ad1];
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Glyph 0 is a diagonal, glyph 1 vertical 4-px stripes, others a checker.
  function automatic bit lit(input int g, input int c, input int r);
    case (g)
      0:       return c == r;
      1:       return (c % 8) < 4;
      default: return ((c + r + g) % 2) == 1;
    endcase
  endfunction

  int m_en [2], m_g [2], m_x [2], m_y [2];
  int s_en [2], s_g [2], s_x [2], s_y [2];
  bit m_pend [2];
  bit prev_vs;

  function automatic bit in_box(input int d, input int x, input int y);
    int box;
    box = 32 << d;
    if (m_en[d] == 0) return 0;
    if (x < m_x[d] || y < m_y[d]) return 0;
    return (x - m_x[d] < box) && (y - m_y[d] < box);
  endfunction

  function automatic bit exp_pix(input int d, input int x, input int y,
                                 input bit d_e);
    if (!d_e || !in_box(d, x, y)) return 0;
    return lit(m_g[d], (x - m_x[d]) >> d, (y - m_y[d]) >> d);
  endfunction

  typedef struct packed {
    logic p0, p1, de, hs, vs;
  } exp_t;

  exp_t e1, e2;
  int   nh;

  task automatic cyc(input int x, input int y, input bit d_e,
                     input bit h, input bit v);
    bit edg;
    @(negedge clk);
    if (nh >= 2) begin
      check("pix0", pix0, e2.p0);
      check("pix1", pix1, e2.p1);
      check("de0",  deo0, e2.de);
      check("hs0",  hso0, e2.hs);
      check("vs0",  vso0, e2.vs);
      check("de1",  deo1, e2.de);
      check("vs1",  vso1, e2.vs);
    end
    e2 = e1;
    px = 11'(x); py = 10'(y); de = d_e; hs = h; vs = v;
    #1;
    e1.p0 = exp_pix(0, x, y, d_e);
    e1.p1 = exp_pix(1, x, y, d_e);
    e1.de = d_e; e1.hs = h; e1.vs = v;
    for (int d = 0; d < 2; d++) begin
      if (d_e && in_box(d, x, y))
        check(d == 0 ? "rom_ad0" : "rom_ad1", d == 0 ? ad0 : ad1,
              32'(m_g[d] * 32 + ((y - m_y[d]) >> d)));
    end
    edg = v && !prev_vs;
    prev_vs = v;
    check("commit0", cm0, edg && m_pend[0]);
    check("commit1", cm1, edg && m_pend[1]);
    for (int d = 0; d < 2; d++) begin
      if (edg && m_pend[d]) begin
        m_en[d] = s_en[d]; m_g[d] = s_g[d];
        m_x[d] = s_x[d];   m_y[d] = s_y[d];
        m_pend[d] = 0;
      end
    end
    if (nh < 2) nh++;
  endtask

  task automatic send(input int d, input int g, input int x, input int y,
                      input bit en);
    logic rdy;
    cyc(0, 0, 0, 0, 0);
    if (d == 0) begin
      c0.cmd_valid = 1; c0.cmd_glyph = 3'(g); c0.cmd_x = 11'(x);
      c0.cmd_y = 10'(y); c0.cmd_en = en; rdy = c0.cmd_ready;
    end else begin
      c1.cmd_valid = 1; c1.cmd_glyph = 3'(g); c1.cmd_x = 11'(x);
      c1.cmd_y = 10'(y); c1.cmd_en = en; rdy = c1.cmd_ready;
    end
    check("cmd_ready", rdy, !m_pend[d]);
    if (!m_pend[d]) begin
      s_en[d] = en; s_g[d] = g; s_x[d] = x; s_y[d] = y;
      m_pend[d] = 1;
    end
    cyc(0, 0, 0, 0, 0);
    c0.cmd_valid = 0;
    c1.cmd_valid = 0;
  endtask

  task automatic frame_edge();
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
  endtask

  task automatic scan(input int y0, input int y1, input int x0,
                      input int x1);
    for (int y = y0; y <= y1; y++) begin
      for (int x = x0; x <= x1; x++) cyc(x, y, 1, 0, 0);
      cyc(0, y, 0, 1, 0);
      cyc(0, y, 0, 0, 0);
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < 2; d++) begin
      m_en[d] = 0; m_g[d] = 0; m_x[d] = 0; m_y[d] = 0;
      m_pend[d] = 0;
    end
  endtask

  initial begin
    for (int g = 0; g < 8; g++)
      for (int r = 0; r < 32; r++)
        for (int c = 0; c < 32; c++)
          mem[g * 32 + r][31 - c] = lit(g, c, r);
    reset = 1; px = '0; py = '0; de = 0; hs = 0; vs = 0;
    c0.cmd_valid = 0; c0.cmd_glyph = '0; c0.cmd_x = '0;
    c0.cmd_y = '0; c0.cmd_en = 0;
    c1.cmd_valid = 0; c1.cmd_glyph = '0; c1.cmd_x = '0;
    c1.cmd_y = '0; c1.cmd_en = 0;
    clear_model();
    e1 = '0; e2 = '0; nh = 0; prev_vs = 1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_pix0", pix0, 0);
    check("rst_de0", deo0, 0);
    check("rst_vs0", vso0, 0);
    check("rst_commit0", cm0, 0);
    check("rst_ready0", c0.cmd_ready, 1);
    check("rst_ready1", c1.cmd_ready, 1);
    check("rom_ce", ce0, 1);
    check("rom_reset", rr0, 1);
    reset = 0;
    #1;
    check("rom_reset_rel", rr0, 0);

    // Frame without a command: dark, syncs delayed by two clocks.
    frame_edge();
    scan(0, 3, 0, 39);

    // Glyph 0 at (100,50) on u0, glyph 1 at (0,0) on the 2x u1.
    send(0, 0, 100, 50, 1);
    send(1, 1, 0, 0, 1);
    frame_edge();
    cyc(100, 50, 1, 0, 0);
    check("ad0_100_50", ad0, 32'h00);
    cyc(10, 20, 1, 0, 0);
    check("ad1_10_20", ad1, 32'h2A);
    scan(48, 83, 96, 135);
    scan(0, 65, 0, 66);

    // Back-pressure while a command is pending.
    send(0, 2, 2030, 0, 1);
    send(0, 0, 100, 50, 1);
    check("ready_pending", c0.cmd_ready, 0);
    frame_edge();
    cyc(0, 0, 0, 0, 0);
    check("ready_after", c0.cmd_ready, 1);
    send(0, 0, 100, 50, 1);

    // Right-edge clipping: nothing wraps onto px 0..13.
    for (int x = 2020; x < 2048; x++) cyc(x, 0, 1, 0, 0);
    for (int x = 0; x <= 20; x++) cyc(x, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);

    // Asynchronous reset while a lit pixel is on the output.
    frame_edge();
    for (int x = 100; x <= 107; x++) cyc(x, 55, 1, 0, 0);
    check("pix_lit_pre_rst", pix0, 1);
    reset = 1;
    #1;
    check("rst_mid_pix0", pix0, 0);
    check("rst_mid_de0", deo0, 0);
    check("rst_mid_ready0", c0.cmd_ready, 1);
    check("rst_mid_pix1", pix1, 0);
    clear_model();
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    nh = 0;
    prev_vs = vs;
    scan(55, 56, 96, 110);
    frame_edge();
    scan(55, 55, 100, 108);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
